// File: rtl/traffic_pkg.sv
// Shared definitions for the country-road sensor and the signal controller:
// light codes driven on the country lamp bus and the sensor FSM encoding.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } sensor_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus counter debouncer for the country-road loop sensor.
// rise/fall are combinational and mark the edge on which the debounced level flips.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear_n,
    input  logic loop_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (s2 != level) && (cnt == CNT_LAST);
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= loop_raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/country_sensor.sv
// Country-road car counter: debounced arrivals, timed departures on GREEN,
// stuck-sensor detection, and a registered car-waiting request X.
module country_sensor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPART_CYCLES   = 8,
    parameter int MAX_CARS        = 15,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic                              clk,
    input  logic                              clear_n,
    input  logic                              loop_raw,
    input  logic [1:0]                        cntry,
    output logic                              X,
    output logic [$clog2(MAX_CARS + 1)-1:0]   queue_cnt,
    output logic                              overflow,
    output logic                              fault
);

    localparam int QW = $clog2(MAX_CARS + 1);
    localparam int TW = $clog2(DEPART_CYCLES + 1);
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [QW-1:0] Q_MAX     = QW'(MAX_CARS);
    localparam logic [TW-1:0] TMR_LAST  = TW'(DEPART_CYCLES - 1);
    localparam logic [SW-1:0] STK_LAST  = SW'(STUCK_CYCLES - 1);

    logic          level;
    logic          rise;
    logic          fall;
    logic          green;
    logic [TW-1:0] tmr;
    logic [SW-1:0] stk;
    logic          dep;
    logic          arr;
    logic          stuck;
    logic [QW-1:0] q_next;
    logic          ovf_set;
    sensor_state_t state;
    sensor_state_t st_norm;
    sensor_state_t st_next;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .clear_n (clear_n),
        .loop_raw(loop_raw),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    // Codes 0, 1 and the illegal 3 all count as not green.
    assign green = (cntry == GREEN);
    assign dep   = green && (tmr == TMR_LAST) && (queue_cnt != '0);
    assign arr   = rise && (state != ST_FAULT);
    assign stuck = level && (stk == STK_LAST);

    always_comb begin
        q_next  = queue_cnt;
        ovf_set = 1'b0;
        if (arr && !dep) begin
            if (queue_cnt == Q_MAX) begin
                ovf_set = 1'b1;
            end else begin
                q_next = queue_cnt + 1'b1;
            end
        end else if (dep && !arr) begin
            q_next = queue_cnt - 1'b1;
        end
    end

    always_comb begin
        if (q_next == '0) begin
            st_norm = ST_EMPTY;
        end else if (green) begin
            st_norm = ST_DRAIN;
        end else begin
            st_norm = ST_WAIT;
        end

        // Releasing the sensor always wins over staying in or entering FAULT.
        if (fall) begin
            st_next = st_norm;
        end else if (stuck || state == ST_FAULT) begin
            st_next = ST_FAULT;
        end else begin
            st_next = st_norm;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            tmr       <= '0;
            stk       <= '0;
            queue_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (!green || tmr == TMR_LAST) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end

            if (!level) begin
                stk <= '0;
            end else if (stk != STK_LAST) begin
                stk <= stk + 1'b1;
            end

            queue_cnt <= q_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // FSM with outputs registered from the next state, so X and fault
    // have no combinational path from loop_raw or cntry.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_EMPTY;
            X     <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= st_next;
            X     <= (st_next != ST_EMPTY);
            fault <= (st_next == ST_FAULT);
        end
    end

endmodule

// File: doc/country_sensor.md
COUNTRY_SENSOR -- requirements
Module: country_sensor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a loop-sensor level change.
REQ-003 Parameter DEPART_CYCLES, default 8: cycles of country GREEN per departing car.
REQ-004 Parameter MAX_CARS, default 15: queue saturation value; 4-bit counter at default.
REQ-005 Parameter STUCK_CYCLES, default 64: continuous debounced-high cycles that declare a stuck sensor.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 clear_n  input  1  asynchronous active-low reset.
REQ-008 loop_raw  input  1  raw country-road loop sensor, asynchronous to clk, may glitch.
REQ-009 cntry  input  2  country light code from the signal controller: RED=0, YELLOW=1, GREEN=2; code 3 is illegal.
REQ-010 X  output  1  car-waiting request to the signal controller.
REQ-011 queue_cnt  output  4  number of cars currently waiting.
REQ-012 overflow  output  1  sticky flag: an arrival occurred while queue_cnt was at MAX_CARS.
REQ-013 fault  output  1  stuck-sensor indication.

Function
REQ-014 loop_raw SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 The debounced level SHALL change only after s2 differs from it for DEBOUNCE_CYCLES consecutive edges; any cycle where s2 equals it clears the debounce counter.
REQ-016 An arrival SHALL be the debounced level's 0->1 transition, applied to queue_cnt on the same edge; total latency = 2 + DEBOUNCE_CYCLES edges after loop_raw goes stable high.
REQ-017 Only cntry==GREEN SHALL count as green; codes 0, 1 and 3 are not green.
REQ-018 The departure timer SHALL count edges while cntry==GREEN and clear to 0 whenever cntry!=GREEN.
REQ-019 A departure SHALL occur on the edge the timer reaches DEPART_CYCLES-1, provided queue_cnt>0; the timer then wraps to 0 and keeps counting while GREEN.
REQ-020 Arrival only: queue_cnt +1, saturating at MAX_CARS; an arrival at MAX_CARS sets overflow.
REQ-021 Departure only: queue_cnt -1; no departure is generated when queue_cnt==0, so the counter never underflows.
REQ-022 Simultaneous arrival and departure: queue_cnt unchanged and overflow not set.
REQ-023 FSM states and transitions:
- EMPTY: queue_cnt==0.
- WAIT: queue_cnt>0 and not GREEN.
- DRAIN: queue_cnt>0 and GREEN.
- FAULT: stuck sensor.
- Next state is evaluated every edge from the updated queue_cnt and cntry.
REQ-024 Entering FAULT: the debounced level stays high for STUCK_CYCLES consecutive edges, from any state.
REQ-025 In FAULT, arrivals SHALL be ignored and departures still processed.
REQ-026 Leaving FAULT: on the debounced 1->0 transition, go to EMPTY or WAIT/DRAIN per queue_cnt.
REQ-027 fault SHALL be 1 exactly in FAULT.
REQ-028 X SHALL be 1 in WAIT, DRAIN and FAULT, else 0; it is decoded from registered state only, with no combinational path from loop_raw or cntry.
REQ-029 overflow SHALL remain set until reset.

Reset
REQ-030 clear_n low SHALL immediately clear s1, s2, the debounced level, all counters and overflow, and force state EMPTY.
REQ-031 While clear_n is low: X=0, queue_cnt=0, overflow=0, fault=0.
REQ-032 Reset asserted mid-debounce or mid-departure SHALL discard the partial count; operation resumes from the first edge after release.

Structure
REQ-033 The light codes RED/YELLOW/GREEN and the FSM state encoding SHALL live in shared package traffic_pkg, also used by the signal controller.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, sensor_debounce, outputting the debounced level and a rise pulse.

Verification
REQ-035 Reset: clear_n=0 with loop_raw=1 and cntry=GREEN -> X=0, queue_cnt=0, overflow=0, fault=0 throughout.
REQ-036 Glitch: loop_raw high for 3 cycles, cntry=RED -> queue_cnt stays 0, X stays 0.
REQ-037 Single car: loop_raw high for 10 cycles, cntry=RED -> queue_cnt=1 and X=1 at edge 6; then cntry=GREEN -> queue_cnt=0 and X=0 on the 8th GREEN edge.
REQ-038 Saturation: 17 debounced arrivals with cntry=RED -> queue_cnt=15, overflow=1; a following departure gives queue_cnt=14 with overflow still 1.
REQ-039 Simultaneous: queue_cnt=3, arrival edge coincides with departure edge -> queue_cnt stays 3.
REQ-040 Stuck sensor: loop_raw held high for 80 cycles with queue_cnt=0 after departures -> fault=1 and X=1 at the 64th debounced-high edge; loop_raw low -> fault=0 and X=0 after 2+4 edges.
